sram_bus_initiator: RTL and testbench

//  Initiator side of the SRAM-style strobe bus served by the ssdram responder.

---
 rtl/sram_bus_pkg.sv | 19 +
 rtl/sram_bus_initiator.sv | 91 +++++++++
 tb/tb_sram_bus_initiator.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_pkg.sv
// sram_bus_pkg: shared states, default timing and strobe encodings for the SRAM strobe-bus initiator
package sram_bus_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_ACCESS_CYC = 6;
  localparam int DEF_HOLD_CYC = 1;
  // strobe vectors are {n_cs, n_oe, n_we}
  localparam logic [2:0] STROBES_IDLE = 3'b111;
  localparam logic [2:0] STROBES_CS = 3'b011;
  localparam logic [2:0] STROBES_RD = 3'b001;
  localparam logic [2:0] STROBES_WR = 3'b010;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/sram_bus_initiator.sv
// sram_bus_initiator: turns a valid/ready request stream into timed CS/OE/WE strobe sequences
module sram_bus_initiator
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int ACCESS_CYC = DEF_ACCESS_CYC,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              n_sram_cs,
  output logic              n_sram_oe,
  output logic              n_sram_we
);
  localparam int CW = $clog2(max3(SETUP_CYC, ACCESS_CYC, HOLD_CYC) + 1);
  localparam logic [CW-1:0] SC = CW'(SETUP_CYC);
  localparam logic [CW-1:0] AC = CW'(ACCESS_CYC);
  localparam logic [CW-1:0] HC = CW'(HOLD_CYC);
  if (ACCESS_CYC < 1) begin : g_bad_access
    $error("ACCESS_CYC must be at least 1");
  end
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic we, we_nxt, accept, last;
  logic [2:0] stb, stb_nxt;
  assign accept = state == IDLE && req_valid && req_ready;
  assign last = cnt == CW'(1);
  assign {n_sram_cs, n_sram_oe, n_sram_we} = stb;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    we_nxt = accept ? req_we : we;
    case (state)
      IDLE: begin
        state_nxt = accept ? (SETUP_CYC > 0 ? SETUP : ACCESS) : IDLE;
        cnt_nxt = accept ? (SETUP_CYC > 0 ? SC : AC) : cnt;
      end
      SETUP: begin
        state_nxt = last ? ACCESS : SETUP;
        cnt_nxt = last ? AC : cnt - CW'(1);
      end
      ACCESS: begin
        state_nxt = !last ? ACCESS : (HOLD_CYC > 0 ? HOLD : IDLE);
        cnt_nxt = last ? HC : cnt - CW'(1);
      end
      HOLD: begin
        state_nxt = last ? IDLE : HOLD;
        cnt_nxt = last ? cnt : cnt - CW'(1);
      end
    endcase
    // strobes are registered from the next state so they change exactly on phase boundaries
    stb_nxt = state_nxt == IDLE ? STROBES_IDLE :
              state_nxt == ACCESS ? (we_nxt ? STROBES_WR : STROBES_RD) : STROBES_CS;
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state <= IDLE;
      cnt <= '0;
      we <= 1'b0;
      stb <= STROBES_IDLE;
      sram_addr <= '0;
      sram_dout <= '0;
      rsp_rdata <= '0;
      rsp_valid <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      we <= we_nxt;
      stb <= stb_nxt;
      rsp_valid <= state != IDLE && state_nxt == IDLE;
      req_ready <= state_nxt == IDLE;
      if (accept) begin
        sram_addr <= req_addr;
        sram_dout <= req_wdata;
      end
      if (state == ACCESS && last && !we) rsp_rdata <= sram_din;
    end
endmodule

// File: tb/tb_sram_bus_initiator.sv
// tb_sram_bus_initiator: directed and random checks of the SRAM strobe-bus initiator against a responder model
module tb_sram_bus_initiator;
  logic clk, n_reset;
  logic req_valid, req_ready, req_we, rsp_valid;
  logic [18:0] req_addr, sram_addr;
  logic [7:0] req_wdata, rsp_rdata, sram_dout, sram_din;
  logic n_sram_cs, n_sram_oe, n_sram_we;
  logic f_req_valid, f_req_ready, f_req_we, f_rsp_valid;
  logic [18:0] f_req_addr, f_sram_addr;
  logic [7:0] f_req_wdata, f_rsp_rdata, f_sram_dout, f_sram_din;
  logic f_n_sram_cs, f_n_sram_oe, f_n_sram_we;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int tests = 0, fails = 0;

  sram_bus_initiator dut (
    .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .n_sram_cs(n_sram_cs), .n_sram_oe(n_sram_oe), .n_sram_we(n_sram_we)
  );

  sram_bus_initiator #(.SETUP_CYC(0), .ACCESS_CYC(1), .HOLD_CYC(0)) dut_fast (
    .clk(clk), .n_reset(n_reset), .req_valid(f_req_valid), .req_ready(f_req_ready), .req_we(f_req_we),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata), .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
    .sram_addr(f_sram_addr), .sram_dout(f_sram_dout), .sram_din(f_sram_din),
    .n_sram_cs(f_n_sram_cs), .n_sram_oe(f_n_sram_oe), .n_sram_we(f_n_sram_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // responder: memory aliased on the low address byte, reloaded with a known pattern on reset
  assign sram_din = mem[sram_addr[7:0]];
  assign f_sram_din = 8'h5A;
  always @(posedge clk or negedge n_reset)
    if (!n_reset) for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hB5;
    else if (!n_sram_cs && !n_sram_we) mem[sram_addr[7:0]] <= sram_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    check("oe_we_overlap", 32'(!n_sram_oe && !n_sram_we), 0);
    check("strobe_without_cs", 32'(n_sram_cs && (!n_sram_oe || !n_sram_we)), 0);
    check("fast_oe_we_overlap", 32'(!f_n_sram_oe && !f_n_sram_we), 0);
    check("fast_strobe_without_cs", 32'(f_n_sram_cs && (!f_n_sram_oe || !f_n_sram_we)), 0);
  end

  // called at a negedge; returns at the negedge of the rsp_valid cycle (lat counts cycles after accept)
  task automatic xfer(input logic w, input logic [18:0] a, input logic [7:0] d, input bit hold,
                      output int lat, output int ncs, output int noe, output int nwe,
                      output bit stable, output logic [7:0] rd);
    int guard = 0;
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    lat = 0; ncs = 0; noe = 0; nwe = 0; stable = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !hold) req_valid = 1'b0;
      if (!n_sram_cs) ncs++;
      if (!n_sram_oe) noe++;
      if (!n_sram_we) nwe++;
      if (!n_sram_cs && (sram_addr !== a || (w && sram_dout !== d))) stable = 1'b0;
    end while (!rsp_valid && lat < 50);
    rd = rsp_rdata;
  endtask

  initial begin
    int lat, ncs, noe, nwe, guard;
    bit stable, saw_rsp;
    logic [7:0] rd;
    logic w;
    logic [18:0] a;
    logic [7:0] d;
    n_reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    f_req_valid = 1'b0; f_req_we = 1'b0; f_req_addr = '0; f_req_wdata = '0;
    @(negedge clk);
    check("rst_cs", 32'(n_sram_cs), 1);
    check("rst_oe", 32'(n_sram_oe), 1);
    check("rst_we", 32'(n_sram_we), 1);
    check("rst_addr", 32'(sram_addr), 0);
    check("rst_dout", 32'(sram_dout), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    n_reset = 1'b1;
    #1 check("ready_before_edge", 32'(req_ready), 0);
    @(negedge clk);
    check("ready_after_release", 32'(req_ready), 1);

    xfer(1'b0, 19'h00010, 8'h00, 1'b0, lat, ncs, noe, nwe, stable, rd);
    check("rd_latency", 32'(lat), 9);
    check("rd_cs_cycles", 32'(ncs), 8);
    check("rd_oe_cycles", 32'(noe), 6);
    check("rd_we_cycles", 32'(nwe), 0);
    check("rd_addr_stable", 32'(stable), 1);
    check("rd_data", 32'(rd), 32'h A5);

    xfer(1'b1, 19'h7FFFF, 8'h3C, 1'b0, lat, ncs, noe, nwe, stable, rd);
    check("wr_latency", 32'(lat), 9);
    check("wr_cs_cycles", 32'(ncs), 8);
    check("wr_we_cycles", 32'(nwe), 6);
    check("wr_oe_cycles", 32'(noe), 0);
    check("wr_addr_data_stable", 32'(stable), 1);

    xfer(1'b1, 19'h00042, 8'h3C, 1'b1, lat, ncs, noe, nwe, stable, rd);
    check("b2b_wr_latency", 32'(lat), 9);
    check("b2b_cs_high", 32'(n_sram_cs), 1);
    check("b2b_ready", 32'(req_ready), 1);
    xfer(1'b0, 19'h00042, 8'h00, 1'b0, lat, ncs, noe, nwe, stable, rd);
    check("b2b_rd_latency", 32'(lat), 9);
    check("b2b_rd_cs_cycles", 32'(ncs), 8);
    check("b2b_rd_data", 32'(rd), 32'h3C);

    f_req_valid = 1'b1; f_req_we = 1'b0; f_req_addr = 19'h00020;
    guard = 0;
    while (!f_req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    lat = 0; noe = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) f_req_valid = 1'b0;
      if (!f_n_sram_oe) noe++;
    end while (!f_rsp_valid && lat < 20);
    check("fast_latency", 32'(lat), 2);
    check("fast_oe_cycles", 32'(noe), 1);
    check("fast_rdata", 32'(f_rsp_rdata), 32'h5A);

    req_valid = 1'b1; req_we = 1'b1; req_addr = 19'h00077; req_wdata = 8'h99;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_we_low", 32'(n_sram_we), 0);
    #2 n_reset = 1'b0;
    #1;
    check("mid_rst_we", 32'(n_sram_we), 1);
    check("mid_rst_cs", 32'(n_sram_cs), 1);
    check("mid_rst_oe", 32'(n_sram_oe), 1);
    check("mid_rst_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    n_reset = 1'b1;
    #1 check("mid_rst_ready_low", 32'(req_ready), 0);
    saw_rsp = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_high", 32'(req_ready), 1);
    repeat (12) begin
      if (rsp_valid) saw_rsp = 1'b1;
      @(negedge clk);
    end
    check("mid_rst_no_rsp", 32'(saw_rsp), 0);

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hB5;
    for (int n = 0; n < 1000; n++) begin
      w = 1'($urandom_range(0, 1));
      a = 19'($urandom_range(0, 255));
      d = 8'($urandom);
      xfer(w, a, d, 1'b0, lat, ncs, noe, nwe, stable, rd);
      check("rand_latency", 32'(lat), 9);
      if (w) ref_mem[a[7:0]] = d;
      else check("rand_rdata", 32'(rd), 32'(ref_mem[a[7:0]]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
